mmio_bridge: RTL and testbench
==============================

# mmio_bridge

Parametrised memory-mapped I/O bridge between the AVR core's data bus and NSLOT peripheral pages. It decodes the page, presents a registered request to one slot and completes it either with a fixed latency or with a per-slot stall/ack handshake. It returns latched read data and a ready strobe to the core, and aborts hung or unmapped accesses with an error flag. It replaces fixed-decode, fixed-latency peripheral glue and sits between the CPU data port and basic I/O, keypad, sound, vgaterm and future peripherals.

## Interface
Parameters:
- ADDR_W, 15, CPU-side I/O address width.
- PAGE_BITS, 8, in-page offset width (256-byte pages).
- NSLOT, 4, number of peripheral slots; slot s owns page s.
- ACK_MASK, 4'b1000, bit s=1: slot s uses stall/ack; bit s=0: fixed one-cycle slot.
- TIMEOUT, 255, maximum cycles spent in REQ+WAIT before abort (1..255).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- re, we  in  1  CPU read/write request; held until ready.
- addr  in  ADDR_W  CPU I/O address.
- data_write  in  8  CPU write data.
- data_read  out  8  latched read data.
- ready  out  1  one-cycle completion strobe.
- bus_err  out  1  sticky error flag.
- err_addr  out  ADDR_W  address of the first erroring access.
- err_clr  in  1  clears bus_err and err_addr.
- slot_cyc  out  NSLOT  one-hot cycle-active per slot.
- slot_stb  out  NSLOT  one-hot request strobe per slot.
- slot_we  out  1  registered write enable.
- slot_addr  out  PAGE_BITS  registered in-page offset.
- slot_wdata  out  8  registered write data.
- slot_rdata  in  NSLOT*8  read data; slot s in bits [8s+7:8s].
- slot_stall, slot_ack  in  NSLOT  per-slot handshake; ignored for fixed slots.

## Operation
- Reset value of every output is 0, including data_read = 0x00. The FSM resets to IDLE.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: a request is re|we. The page is addr[ADDR_W-1:PAGE_BITS].
  - Mapped page (page < NSLOT): latch offset, data_write and we into slot_*. Set slot_cyc[s] and slot_stb[s], clear the timeout count, and go to REQ.
  - Unmapped page: go straight to DONE. Reads load data_read = 0xFF. Set bus_err and capture err_addr.
- If re and we are both set, the access is a write.
- REQ, fixed slot: sample slot_rdata[s] at the end of the cycle and go to DONE.
- REQ, ack slot: stb is held while slot_stall[s]=1.
  - On !stall with ack: go to DONE.
  - On !stall without ack: drop stb and go to WAIT.
- WAIT: cyc is held. On slot_ack[s], go to DONE and latch rdata if reading.
- Timeout: the count increments in REQ and WAIT. When it reaches TIMEOUT, go to DONE and drop cyc/stb. Reads return 0xFF; bus_err and err_addr are set.
- DONE: ready=1 for one cycle. cyc and stb drop and the FSM returns to IDLE.
  - Requests are never accepted in DONE, so a held re/we is not re-issued until the following IDLE cycle.
- data_read changes only on read completion; writes and idle cycles hold it.
- err_addr records only the first error while bus_err=1.
- err_clr has priority over a simultaneous new error: the flag is clear afterwards. That error is lost.
- An asynchronous reset mid-transaction drops all strobes immediately. It does not pulse ready.

## Timing
- Request seen in IDLE on cycle T: stb is asserted during T+1.
  - Fixed slot: ready and new data_read are visible at T+2.
  - Ack slot: ready comes one cycle after the cycle in which ack is sampled. The minimum is T+2, when ack coincides with the first unstalled stb.
  - Unmapped page: ready at T+1.
  - Timeout: ready at T+1+TIMEOUT.
- ack arriving while stall=1 is ignored.
- ack on a non-selected slot is ignored.
- Maximum throughput is one access per 3 cycles for fixed slots.

## Structure
- Package mmio_pkg holds:
  - the state enum (IDLE/REQ/WAIT/DONE);
  - UNMAPPED_DATA = 8'hFF;
  - the page-index width function, clog2(NSLOT).
- One sub-module, mmio_watchdog: an 8-bit timeout counter with clear, enable and an expired output.
- The decoder and read-data mux stay inline.

## Test plan
- Fixed slot 0 read at 0x0012, slot 0 returns 0x5A:
  - slot_addr=0x12 at T+1; ready and data_read=0x5A at T+2; bus_err=0.
- Ack slot 3 write 0xC3 to 0x0304, stall high 3 cycles then ack 2 cycles later:
  - stb held 4 cycles; slot_wdata=0xC3; ready exactly once, one cycle after ack; data_read unchanged.
- Read at unmapped page 0x0700 (NSLOT=4):
  - ready at T+1; data_read=0xFF; bus_err=1; err_addr=0x0700.
  - A second error does not change err_addr; err_clr clears both.
- Ack slot never acks with TIMEOUT=8:
  - ready at T+9; data_read=0xFF; bus_err=1; cyc low after DONE.
- re and we together to slot 1:
  - slot_we=1 and data_read unchanged.
- rst_n low during WAIT:
  - all outputs 0 asynchronously; next request proceeds normally.

Source files
------------

// File: rtl/mmio_pkg.sv
// ---------------------------------------------------------------------------
// mmio_pkg
// Shared types and constants for the MMIO bridge between the AVR data bus and
// its peripheral pages.
//   state_t        : bridge FSM states (IDLE, REQ, WAIT, DONE)
//   UNMAPPED_DATA  : value returned by reads that hit no slot or time out
//   pageIdxW()     : width of the slot index for a given slot count
// ---------------------------------------------------------------------------
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  localparam logic [7:0] UNMAPPED_DATA = 8'hFF;

  // A single slot still needs a one-bit index so the slot register exists.
  function automatic int pageIdxW(input int nslot);
    return (nslot > 1) ? $clog2(nslot) : 1;
  endfunction

endpackage

// File: rtl/mmio_bridge_if.sv
// ---------------------------------------------------------------------------
// mmio_bridge_if
// Bundles the CPU-side bus and the peripheral-slot bus of the MMIO bridge.
//   CPU side  : re, we, addr, data_write -> bridge; data_read, ready,
//               bus_err, err_addr <- bridge; err_clr -> bridge
//   Slot side : slot_cyc, slot_stb, slot_we, slot_addr, slot_wdata <- bridge;
//               slot_rdata, slot_stall, slot_ack -> bridge
// Modports: slave is the bridge's view, master is the view of whatever drives
// the CPU requests and models the peripherals.
// ---------------------------------------------------------------------------
interface mmio_bridge_if #(
  parameter int ADDR_W    = 15,
  parameter int PAGE_BITS = 8,
  parameter int NSLOT     = 4
);

  logic                   re;
  logic                   we;
  logic [ADDR_W-1:0]      addr;
  logic [7:0]             data_write;
  logic [7:0]             data_read;
  logic                   ready;
  logic                   bus_err;
  logic [ADDR_W-1:0]      err_addr;
  logic                   err_clr;

  logic [NSLOT-1:0]       slot_cyc;
  logic [NSLOT-1:0]       slot_stb;
  logic                   slot_we;
  logic [PAGE_BITS-1:0]   slot_addr;
  logic [7:0]             slot_wdata;
  logic [NSLOT*8-1:0]     slot_rdata;
  logic [NSLOT-1:0]       slot_stall;
  logic [NSLOT-1:0]       slot_ack;

  modport slave (
    input  re, we, addr, data_write, err_clr,
    input  slot_rdata, slot_stall, slot_ack,
    output data_read, ready, bus_err, err_addr,
    output slot_cyc, slot_stb, slot_we, slot_addr, slot_wdata
  );

  modport master (
    output re, we, addr, data_write, err_clr,
    output slot_rdata, slot_stall, slot_ack,
    input  data_read, ready, bus_err, err_addr,
    input  slot_cyc, slot_stb, slot_we, slot_addr, slot_wdata
  );

endinterface

// File: rtl/mmio_watchdog.sv
// ---------------------------------------------------------------------------
// mmio_watchdog
// 8-bit cycle counter that flags a hung slot access.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_clr       : restart the count from zero
//   i_en        : count this cycle (bridge is in REQ or WAIT)
//   o_expired   : this enabled cycle is the TIMEOUT-th one of the access
// ---------------------------------------------------------------------------
module mmio_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_count;

  // The count holds the number of enabled cycles already completed, so the
  // current cycle is the last allowed one when it equals TIMEOUT-1. It
  // saturates rather than wrapping in case the enable is ever left on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 8'd0;
    end else if (i_clr) begin
      r_count <= 8'd0;
    end else if (i_en && (r_count != 8'hFF)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_expired = i_en && (r_count == LAST);

endmodule

// File: rtl/mmio_bridge.sv
// ---------------------------------------------------------------------------
// mmio_bridge
// Decodes the CPU I/O page, issues a registered request to one peripheral
// slot, and completes it either after a fixed single cycle or via the slot's
// stall/ack handshake. Hung or unmapped accesses are aborted with 0xFF read
// data and a sticky error flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mmio_bridge_if.slave carrying the CPU request/response,
//                error reporting and the per-slot request/handshake signals
// ---------------------------------------------------------------------------
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int               ADDR_W    = 15,
  parameter int               PAGE_BITS = 8,
  parameter int               NSLOT     = 4,
  parameter logic [NSLOT-1:0] ACK_MASK  = NSLOT'(4'b1000),
  parameter int               TIMEOUT   = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  mmio_bridge_if.slave bus
);

  localparam int PG_W   = ADDR_W - PAGE_BITS;
  localparam int SIDX_W = pageIdxW(NSLOT);

  state_t                r_state;
  logic [SIDX_W-1:0]     r_slot;
  logic [NSLOT-1:0]      r_cyc;
  logic [NSLOT-1:0]      r_stb;
  logic                  r_we;
  logic [PAGE_BITS-1:0]  r_addr;
  logic [7:0]            r_wdata;
  logic [7:0]            r_rdata;
  logic                  r_ready;
  logic                  r_err;
  logic [ADDR_W-1:0]     r_errAddr;
  logic [ADDR_W-1:0]     r_reqAddr;

  logic [PG_W-1:0]       w_page;
  logic [SIDX_W-1:0]     w_slotIdx;
  logic                  w_req;
  logic                  w_mapped;
  logic [7:0]            w_rdata;
  logic                  w_stall;
  logic                  w_ack;
  logic                  w_fixed;
  logic                  w_active;
  logic                  w_complete;
  logic                  w_expired;
  logic                  w_errEvent;
  logic [ADDR_W-1:0]     w_errAddrIn;
  logic                  w_wdClr;

  assign w_page    = bus.addr[ADDR_W-1:PAGE_BITS];
  assign w_slotIdx = w_page[SIDX_W-1:0];
  assign w_req     = bus.re | bus.we;
  assign w_mapped  = (int'(w_page) < NSLOT);
  assign w_active  = (r_state == REQ) || (r_state == WAIT);
  assign w_wdClr   = (r_state == IDLE);

  // Select the read data and handshake of the slot currently being served.
  // Fixed slots never look at stall/ack, so their handshake lines are don't-care.
  always_comb begin
    w_rdata = 8'h00;
    w_stall = 1'b0;
    w_ack   = 1'b0;
    w_fixed = 1'b0;
    for (int s = 0; s < NSLOT; s++) begin
      if (r_slot == SIDX_W'(s)) begin
        w_rdata = bus.slot_rdata[8*s +: 8];
        w_stall = bus.slot_stall[s];
        w_ack   = bus.slot_ack[s];
        w_fixed = !ACK_MASK[s];
      end
    end
  end

  // A slot finishes either after its single fixed cycle or when it acks; an
  // ack during REQ only counts once the slot is no longer stalling. Normal
  // completion wins over a timeout landing in the same cycle.
  always_comb begin
    w_complete  = ((r_state == REQ) && (w_fixed || (!w_stall && w_ack))) ||
                  ((r_state == WAIT) && w_ack);
    w_errEvent  = ((r_state == IDLE) && w_req && !w_mapped) ||
                  (w_active && w_expired && !w_complete);
    w_errAddrIn = (r_state == IDLE) ? bus.addr : r_reqAddr;
  end

  mmio_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_wdClr),
    .i_en      (w_active),
    .o_expired (w_expired)
  );

  // Sticky error flag. Only the first failing address is kept until software
  // clears it, and a clear in the same cycle as a new error discards that error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err     <= 1'b0;
      r_errAddr <= '0;
    end else if (bus.err_clr) begin
      r_err     <= 1'b0;
      r_errAddr <= '0;
    end else if (w_errEvent && !r_err) begin
      r_err     <= 1'b1;
      r_errAddr <= w_errAddrIn;
    end
  end

  // Bridge FSM. ready is raised on the transition into DONE so it is high for
  // exactly the DONE cycle; cyc/stb drop on the same transition. DONE always
  // returns to IDLE so a request still held by the CPU is not re-issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_slot    <= '0;
      r_cyc     <= '0;
      r_stb     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= 8'h00;
      r_rdata   <= 8'h00;
      r_ready   <= 1'b0;
      r_reqAddr <= '0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_reqAddr <= bus.addr;
            if (w_mapped) begin
              r_slot  <= w_slotIdx;
              r_we    <= bus.we;
              r_addr  <= bus.addr[PAGE_BITS-1:0];
              r_wdata <= bus.data_write;
              r_cyc   <= NSLOT'(1) << w_slotIdx;
              r_stb   <= NSLOT'(1) << w_slotIdx;
              r_state <= REQ;
            end else begin
              if (!bus.we) begin
                r_rdata <= UNMAPPED_DATA;
              end
              r_ready <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        REQ, WAIT: begin
          if (w_complete) begin
            if (!r_we) begin
              r_rdata <= w_rdata;
            end
            r_cyc   <= '0;
            r_stb   <= '0;
            r_ready <= 1'b1;
            r_state <= DONE;
          end else if (w_expired) begin
            if (!r_we) begin
              r_rdata <= UNMAPPED_DATA;
            end
            r_cyc   <= '0;
            r_stb   <= '0;
            r_ready <= 1'b1;
            r_state <= DONE;
          end else if ((r_state == REQ) && !w_stall) begin
            r_stb   <= '0;
            r_state <= WAIT;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.data_read  = r_rdata;
  assign bus.ready      = r_ready;
  assign bus.bus_err    = r_err;
  assign bus.err_addr   = r_errAddr;
  assign bus.slot_cyc   = r_cyc;
  assign bus.slot_stb   = r_stb;
  assign bus.slot_we    = r_we;
  assign bus.slot_addr  = r_addr;
  assign bus.slot_wdata = r_wdata;

endmodule

// File: tb/tb_mmio_bridge.sv
// ---------------------------------------------------------------------------
// tb_mmio_bridge
// Directed scoreboard bench for mmio_bridge (NSLOT=4, slot 3 handshaked,
// TIMEOUT=8). Each issued access pushes its expected response; a monitor
// pops and compares whenever ready is seen.
// ---------------------------------------------------------------------------
module tb_mmio_bridge;

  localparam int ADDR_W    = 15;
  localparam int PAGE_BITS = 8;
  localparam int NSLOT     = 4;
  localparam int TIMEOUT   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mmio_bridge_if #(
    .ADDR_W    (ADDR_W),
    .PAGE_BITS (PAGE_BITS),
    .NSLOT     (NSLOT)
  ) bus ();

  mmio_bridge #(
    .ADDR_W    (ADDR_W),
    .PAGE_BITS (PAGE_BITS),
    .NSLOT     (NSLOT),
    .ACK_MASK  (4'b1000),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string             name;
    logic [7:0]        data;
    logic              err;
    logic [ADDR_W-1:0] errAddr;
    int                issueCyc;
    int                latency;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cycleNo    = 0;

  // Free-running cycle number used to measure request-to-ready latency.
  always @(posedge clk) cycleNo <= cycleNo + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Every output of the bridge must be zero while reset is asserted.
  task automatic checkAllZero(input string name);
    checkOutput({name, "_cpu"},
                {bus.data_read, bus.ready, bus.bus_err, bus.err_addr}, 64'd0);
    checkOutput({name, "_slot"},
                {bus.slot_cyc, bus.slot_stb, bus.slot_we, bus.slot_addr, bus.slot_wdata},
                64'd0);
  endtask

  // Drive a CPU request (caller is positioned at a falling edge in IDLE) and
  // record what the bridge must return when it raises ready.
  task automatic applyStimulus(input string name, input logic re, input logic we,
                               input logic [ADDR_W-1:0] addr, input logic [7:0] wdata,
                               input logic [7:0] expData, input logic expErr,
                               input logic [ADDR_W-1:0] expErrAddr, input int expLat);
    exp_t e;
    e.name     = name;
    e.data     = expData;
    e.err      = expErr;
    e.errAddr  = expErrAddr;
    e.issueCyc = cycleNo;
    e.latency  = expLat;
    expQ.push_back(e);
    bus.re         = re;
    bus.we         = we;
    bus.addr       = addr;
    bus.data_write = wdata;
  endtask

  // Hold the request until ready, release it, then step into the next IDLE cycle.
  task automatic waitReady(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_ready_wait: got no ready within 300 cycles, expected ready", name);
    end
    bus.re = 1'b0;
    bus.we = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every ready pulse consumes one expected response.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.ready) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_ready: got ready=1, expected no pending access");
      end else begin
        e = expQ.pop_front();
        checkOutput({e.name, "_data"}, bus.data_read, e.data);
        checkOutput({e.name, "_err"}, bus.bus_err, e.err);
        checkOutput({e.name, "_erraddr"}, bus.err_addr, e.errAddr);
        checkOutput({e.name, "_latency"}, cycleNo - e.issueCyc, e.latency);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_time_limit: got no end of test, expected $finish");
    $fatal(1, "[TB] time limit exceeded");
  end

  initial begin
    int stbCount;
    bus.re         = 1'b0;
    bus.we         = 1'b0;
    bus.addr       = '0;
    bus.data_write = 8'h00;
    bus.err_clr    = 1'b0;
    bus.slot_stall = '0;
    bus.slot_ack   = '0;
    bus.slot_rdata = {8'h33, 8'h22, 8'h11, 8'h5A};
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Fixed slot 0 read.
    applyStimulus("fixed_rd_s0", 1'b1, 1'b0, 15'h0012, 8'h00, 8'h5A, 1'b0, 15'h0, 2);
    @(negedge clk);
    checkOutput("s0_slot_addr", bus.slot_addr, 8'h12);
    checkOutput("s0_slot_stb", bus.slot_stb, 4'b0001);
    waitReady("fixed_rd_s0");

    // Handshaked slot 3 write: stalled 3 cycles, unstalled without ack, ack
    // two cycles later. Acks while stalled or on other slots must be ignored.
    applyStimulus("ack_wr_s3", 1'b0, 1'b1, 15'h0304, 8'hC3, 8'h5A, 1'b0, 15'h0, 7);
    bus.slot_stall = 4'b1000;
    stbCount = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (bus.slot_stb[3]) stbCount++;
      if (k == 1) begin
        checkOutput("s3_slot_wdata", bus.slot_wdata, 8'hC3);
        checkOutput("s3_slot_we", bus.slot_we, 1'b1);
      end
      bus.slot_ack = (k == 2) ? 4'b1000 : 4'b0000;
    end
    @(negedge clk);
    if (bus.slot_stb[3]) stbCount++;
    bus.slot_stall = 4'b0000;
    bus.slot_ack   = 4'b0000;
    @(negedge clk);
    if (bus.slot_stb[3]) stbCount++;
    checkOutput("s3_wait_cyc", bus.slot_cyc, 4'b1000);
    bus.slot_ack = 4'b0111;
    @(negedge clk);
    if (bus.slot_stb[3]) stbCount++;
    bus.slot_ack = 4'b1000;
    @(negedge clk);
    bus.slot_ack = 4'b0000;
    checkOutput("s3_stb_cycles", stbCount, 4);
    waitReady("ack_wr_s3");

    // Unmapped read, then a second error that must not move err_addr.
    applyStimulus("unmapped_rd", 1'b1, 1'b0, 15'h0700, 8'h00, 8'hFF, 1'b1, 15'h0700, 1);
    waitReady("unmapped_rd");
    applyStimulus("unmapped_wr2", 1'b0, 1'b1, 15'h0A55, 8'h99, 8'hFF, 1'b1, 15'h0700, 1);
    waitReady("unmapped_wr2");
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    checkOutput("errclr_flag", bus.bus_err, 1'b0);
    checkOutput("errclr_addr", bus.err_addr, 15'h0);

    // Further fixed-slot reads with distinct data and offsets.
    applyStimulus("fixed_rd_s1", 1'b1, 1'b0, 15'h0105, 8'h00, 8'h11, 1'b0, 15'h0, 2);
    waitReady("fixed_rd_s1");
    applyStimulus("fixed_rd_s2", 1'b1, 1'b0, 15'h02FF, 8'h00, 8'h22, 1'b0, 15'h0, 2);
    @(negedge clk);
    checkOutput("s2_slot_addr", bus.slot_addr, 8'hFF);
    checkOutput("s2_slot_stb", bus.slot_stb, 4'b0100);
    waitReady("fixed_rd_s2");

    // re and we together is a write; data_read must keep the last read value.
    applyStimulus("rdwr_s1", 1'b1, 1'b1, 15'h0133, 8'h7E, 8'h22, 1'b0, 15'h0, 2);
    @(negedge clk);
    checkOutput("rdwr_slot_we", bus.slot_we, 1'b1);
    checkOutput("rdwr_slot_wdata", bus.slot_wdata, 8'h7E);
    checkOutput("rdwr_slot_cyc", bus.slot_cyc, 4'b0010);
    waitReady("rdwr_s1");

    // Slot 3 never acks: abort after TIMEOUT cycles.
    applyStimulus("timeout_s3", 1'b1, 1'b0, 15'h0310, 8'h00, 8'hFF, 1'b1, 15'h0310, 1 + TIMEOUT);
    waitReady("timeout_s3");
    checkOutput("timeout_cyc_after", bus.slot_cyc, 4'b0000);

    // err_clr in the same cycle as a new error: the flag ends up clear.
    bus.err_clr = 1'b1;
    applyStimulus("clr_vs_err", 1'b1, 1'b0, 15'h0455, 8'h00, 8'hFF, 1'b0, 15'h0, 1);
    @(negedge clk);
    bus.err_clr = 1'b0;
    waitReady("clr_vs_err");
    checkOutput("clr_vs_err_flag_after", bus.bus_err, 1'b0);

    // Asynchronous reset while slot 3 sits in WAIT.
    bus.re   = 1'b1;
    bus.addr = 15'h0301;
    @(negedge clk);
    @(negedge clk);
    checkOutput("wait_before_reset_cyc", bus.slot_cyc, 4'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    bus.re = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus("post_reset_rd", 1'b1, 1'b0, 15'h0001, 8'h00, 8'h5A, 1'b0, 15'h0, 2);
    waitReady("post_reset_rd");

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
